mem_lsu: RTL and testbench
==========================

MEM_LSU -- requirements
Module: mem_lsu

Interface
REQ-001 SHALL have parameter XLEN, default 32, meaning datapath width; only 32 or 64 are legal.
REQ-002 SHALL have parameter TIMEOUT, default 255, meaning the maximum wait in cycles for mem_ack_i, range 1..65535.
REQ-003 SHALL have ports: clk in 1 clock; rst in 1 asynchronous active-low reset, one clock, all state on posedge clk.
REQ-004 SHALL have ports: op_valid_i in 1 op present; op_load_i in 1; op_store_i in 1; op_size_i in 2, 0=byte 1=half 2=word 3=dword (XLEN=64 only); op_unsigned_i in 1.
REQ-005 SHALL have ports: addr_i in XLEN; reg2_i in XLEN store data; wd_i in 5; wreg_i in 1; wdata_i in XLEN.
REQ-006 SHALL have ports: mem_req_o out 1; mem_we_o out 1; mem_addr_o out XLEN; mem_sel_o out XLEN/8; mem_data_o out XLEN; mem_ack_i in 1; mem_data_i in XLEN.
REQ-007 SHALL have ports: wd_o out 5; wreg_o out 1; wdata_o out XLEN; stall_req_o out 1; exc_misalign_o out 1; bus_err_o out 1.

Function
REQ-008 SHALL implement states IDLE, WAIT, RESP.
REQ-009 IDLE, non-memory op or op_valid_i=0: wd_o, wreg_o, wdata_o pass wd_i, wreg_i, wdata_i combinationally; stall_req_o=0; no bus activity.
REQ-010 IDLE, op_valid_i=1 with load or store: latch the op and operands; drive stall_req_o=1 combinationally; go to WAIT.
REQ-011 WAIT: mem_req_o=1, with mem_addr_o/mem_we_o/mem_sel_o/mem_data_o from the latched values; stall_req_o=1; wreg_o=0.
REQ-012 WAIT with mem_ack_i=1: capture mem_data_i; go to RESP.
REQ-013 RESP: drive stall_req_o=0 and mem_req_o=0; a load drives wreg_o=latched wreg and wdata_o=extracted data; a store drives wreg_o=0; return to IDLE next cycle.
REQ-014 Latency SHALL be 3 cycles from accepting the op to the RESP cycle when ack arrives in the first WAIT cycle, plus 1 per extra wait cycle.
REQ-015 mem_sel_o SHALL be a contiguous mask of 2^op_size_i lanes starting at lane addr[log2(XLEN/8)-1:0].
REQ-016 Store data SHALL replicate reg2_i's low 2^op_size_i bytes across the bus; a full-width store drives reg2_i unchanged.
REQ-017 Load data SHALL be the selected lanes shifted to bit 0, sign-extended unless op_unsigned_i=1; XLEN=32 treats op_size_i=3 as word.
REQ-018 An op is misaligned when addr mod 2^op_size_i != 0; handling is per REQ-026/027.
REQ-019 A wait counter SHALL clear on WAIT entry; if it reaches TIMEOUT without ack, bus_err_o pulses for 1 cycle, mem_req_o drops, wreg_o=0, and the block enters RESP.
REQ-020 mem_ack_i outside WAIT SHALL be ignored.
REQ-021 op_load_i and op_store_i both 1 SHALL be treated as a non-memory op.

Reset
REQ-022 rst=0 SHALL immediately force IDLE and clear the counter and latched op, and drive mem_req_o=0, mem_we_o=0, mem_sel_o=0, mem_addr_o=0, mem_data_o=0, stall_req_o=0, wreg_o=0, wd_o=0, wdata_o=0, exc_misalign_o=0, bus_err_o=0.
REQ-023 Reset asserted in WAIT SHALL abandon the access with no writeback.
REQ-024 Deassertion SHALL take effect at the first posedge clk after rst rises.

Configuration
REQ-025 Macro MEM_MISALIGN_TRAP_EN SHALL select misalignment handling.
REQ-026 With the macro defined, a misaligned op in IDLE SHALL go directly to RESP with no bus request: exc_misalign_o=1 for that RESP cycle, wreg_o=0.
REQ-027 With the macro undefined, the address SHALL be aligned down to 2^op_size_i and the access performed; exc_misalign_o is tied 0.

Verification
REQ-028 XLEN=32, LB addr=0x103, mem_data_i=0x80FF_0000, ack on first WAIT cycle -> sel=1000, RESP wdata_o=0xFFFF_FF80, op to RESP = 3 cycles.
REQ-029 XLEN=32, SH addr=0x202, reg2_i=0x1234_ABCD, ack after 4 WAIT cycles -> mem_we_o=1, sel=1100, mem_data_o=0xABCD_ABCD, stall_req_o high for 5 cycles, wreg_o=0 in RESP.
REQ-030 XLEN=64, LWU addr=0x14, mem_data_i=0x8765_4321_0000_0000 -> sel=0xF0, wdata_o=0x0000_0000_8765_4321.
REQ-031 TIMEOUT=8, load, no ack -> bus_err_o pulses once after 8 WAIT cycles, wreg_o=0, return to IDLE.
REQ-032 LW addr=0x101 -> with MEM_MISALIGN_TRAP_EN: exc_misalign_o=1, mem_req_o never asserted; without: access at mem_addr_o=0x100, sel=1111.
REQ-033 rst driven low mid-WAIT -> mem_req_o and stall_req_o drop without a clock edge; no writeback after release.

Source files
------------

// File: rtl/mem_lsu.sv
// Load/store unit: one outstanding bus access, stalls the pipeline until the response cycle.
// Optional macro MEM_MISALIGN_TRAP_EN traps misaligned ops instead of aligning them down.
module mem_lsu #(
  parameter int unsigned XLEN    = 32,
  parameter int unsigned TIMEOUT = 255
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              op_valid_i,
  input  logic              op_load_i,
  input  logic              op_store_i,
  input  logic [1:0]        op_size_i,
  input  logic              op_unsigned_i,
  input  logic [XLEN-1:0]   addr_i,
  input  logic [XLEN-1:0]   reg2_i,
  input  logic [4:0]        wd_i,
  input  logic              wreg_i,
  input  logic [XLEN-1:0]   wdata_i,
  output logic              mem_req_o,
  output logic              mem_we_o,
  output logic [XLEN-1:0]   mem_addr_o,
  output logic [XLEN/8-1:0] mem_sel_o,
  output logic [XLEN-1:0]   mem_data_o,
  input  logic              mem_ack_i,
  input  logic [XLEN-1:0]   mem_data_i,
  output logic [4:0]        wd_o,
  output logic              wreg_o,
  output logic [XLEN-1:0]   wdata_o,
  output logic              stall_req_o,
  output logic              exc_misalign_o,
  output logic              bus_err_o
);

  localparam int unsigned NB = XLEN / 8;
  localparam int unsigned LB = $clog2(NB);
  localparam logic [15:0] CNT_LAST = 16'(TIMEOUT - 1);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_WAIT = 2'd1;
  localparam logic [1:0] S_RESP = 2'd2;

`ifdef MEM_MISALIGN_TRAP_EN
  localparam bit TRAP_EN = 1'b1;
`else
  localparam bit TRAP_EN = 1'b0;
`endif

  function automatic logic [1:0] eff_size(input logic [1:0] s);
    return (XLEN == 32 && s == 2'd3) ? 2'd2 : s;
  endfunction

  function automatic logic [2:0] low_mask(input logic [1:0] s);
    case (s)
      2'd0:    return 3'b000;
      2'd1:    return 3'b001;
      2'd2:    return 3'b011;
      default: return 3'b111;
    endcase
  endfunction

  logic [1:0]      state;
  logic [15:0]     cnt;
  logic            q_load, q_uns, q_wreg, q_err, q_mis;
  logic [1:0]      q_size;
  logic [XLEN-1:0] q_addr, q_reg2, q_rdata;
  logic [4:0]      q_wd;

  logic            mem_op, misaligned, trap;
  logic [1:0]      in_size;

  always_comb begin
    mem_op     = op_valid_i && (op_load_i ^ op_store_i);
    in_size    = eff_size(op_size_i);
    misaligned = |(addr_i[2:0] & low_mask(in_size));
    trap       = TRAP_EN && misaligned;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state   <= S_IDLE;
      cnt     <= '0;
      q_load  <= 1'b0;
      q_size  <= '0;
      q_uns   <= 1'b0;
      q_addr  <= '0;
      q_reg2  <= '0;
      q_rdata <= '0;
      q_wd    <= '0;
      q_wreg  <= 1'b0;
      q_err   <= 1'b0;
      q_mis   <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (mem_op) begin
            q_load <= op_load_i;
            q_size <= in_size;
            q_uns  <= op_unsigned_i;
            q_addr <= addr_i;
            q_reg2 <= reg2_i;
            q_wd   <= wd_i;
            q_wreg <= wreg_i;
            q_err  <= 1'b0;
            cnt    <= '0;
            q_mis  <= trap;
            state  <= trap ? S_RESP : S_WAIT;
          end
        end
        S_WAIT: begin
          // an ack in the final counted cycle still wins over the timeout
          if (mem_ack_i) begin
            q_rdata <= mem_data_i;
            state   <= S_RESP;
          end else if (cnt == CNT_LAST) begin
            q_err <= 1'b1;
            state <= S_RESP;
          end else begin
            cnt <= cnt + 16'd1;
          end
        end
        S_RESP: begin
          q_err <= 1'b0;
          q_mis <= 1'b0;
          state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  logic [XLEN-1:0] a_addr, st_data, shifted, byte_mask, ld_data;
  logic [LB-1:0]   off;
  logic [NB-1:0]   lane_mask, sel;
  logic            sign;

  always_comb begin
    a_addr  = q_addr & ~XLEN'(low_mask(q_size));
    off     = a_addr[LB-1:0];
    shifted = q_rdata >> {off, 3'b000};
    st_data = '0;
    case (q_size)
      2'd0: begin
        lane_mask = NB'(1);
        byte_mask = XLEN'(8'hFF);
        sign      = shifted[7];
        for (int unsigned i = 0; i < NB; i++) st_data[8*i +: 8] = q_reg2[7:0];
      end
      2'd1: begin
        lane_mask = NB'(3);
        byte_mask = XLEN'(16'hFFFF);
        sign      = shifted[15];
        for (int unsigned i = 0; i < NB / 2; i++) st_data[16*i +: 16] = q_reg2[15:0];
      end
      2'd2: begin
        lane_mask = NB'(15);
        byte_mask = XLEN'(32'hFFFF_FFFF);
        sign      = shifted[31];
        for (int unsigned i = 0; i < NB / 4; i++) st_data[32*i +: 32] = q_reg2[31:0];
      end
      default: begin
        lane_mask = '1;
        byte_mask = '1;
        sign      = shifted[XLEN-1];
        st_data   = q_reg2;
      end
    endcase
    sel     = lane_mask << off;
    ld_data = (shifted & byte_mask) | ((sign && !q_uns) ? ~byte_mask : '0);
  end

  always_comb begin
    mem_req_o      = 1'b0;
    mem_we_o       = 1'b0;
    mem_addr_o     = '0;
    mem_sel_o      = '0;
    mem_data_o     = '0;
    wd_o           = '0;
    wreg_o         = 1'b0;
    wdata_o        = '0;
    stall_req_o    = 1'b0;
    exc_misalign_o = 1'b0;
    bus_err_o      = 1'b0;
    // outputs are gated by rst so the passthrough paths are also zero during reset
    if (rst) begin
      case (state)
        S_IDLE: begin
          wd_o        = wd_i;
          wdata_o     = wdata_i;
          wreg_o      = wreg_i && !mem_op;
          stall_req_o = mem_op;
        end
        S_WAIT: begin
          mem_req_o   = 1'b1;
          mem_we_o    = !q_load;
          mem_addr_o  = a_addr;
          mem_sel_o   = sel;
          mem_data_o  = st_data;
          stall_req_o = 1'b1;
          wd_o        = q_wd;
        end
        S_RESP: begin
          wd_o           = q_wd;
          wreg_o         = q_load && q_wreg && !q_err && !q_mis;
          wdata_o        = q_load ? ld_data : '0;
          bus_err_o      = q_err;
          exc_misalign_o = TRAP_EN && q_mis;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_lsu.sv
// Self-checking bench for mem_lsu: directed vector table, hand-written reset/ack sequences,
// and randomized ops checked against an arithmetic reference model (32-bit and 64-bit instances).
module tb_mem_lsu;

`ifdef MEM_MISALIGN_TRAP_EN
  localparam bit TRAP = 1'b1;
`else
  localparam bit TRAP = 1'b0;
`endif

  typedef struct {
    bit          is64;
    bit          ld;
    bit          st;
    logic [1:0]  sz;
    bit          uns;
    logic [63:0] addr;
    logic [63:0] reg2;
    logic [63:0] rdata;
    int unsigned dly;
    logic [63:0] e_addr;
    logic [7:0]  e_sel;
    logic [63:0] e_mdata;
    logic [63:0] e_wdata;
  } vec_t;

  logic        clk, rst;
  logic        valid, use64, ackv, ld, st, uns, wreg_in;
  logic [1:0]  size;
  logic [63:0] addr, reg2, rdata, wdata_in;
  logic [4:0]  wd_in;
  logic        v32, v64, a32, a64;

  assign v32 = valid && !use64;
  assign v64 = valid && use64;
  assign a32 = ackv && !use64;
  assign a64 = ackv && use64;

  logic        req32, we32, wreg32, stall32, mis32, err32;
  logic [31:0] maddr32, mdata32, wdata32;
  logic [3:0]  sel32;
  logic [4:0]  wd32;
  logic        req64, we64, wreg64, stall64, mis64, err64;
  logic [63:0] maddr64, mdata64, wdata64;
  logic [7:0]  sel64;
  logic [4:0]  wd64;

  mem_lsu #(.XLEN(32), .TIMEOUT(8)) d32 (
    .clk(clk), .rst(rst), .op_valid_i(v32), .op_load_i(ld), .op_store_i(st),
    .op_size_i(size), .op_unsigned_i(uns), .addr_i(addr[31:0]), .reg2_i(reg2[31:0]),
    .wd_i(wd_in), .wreg_i(wreg_in), .wdata_i(wdata_in[31:0]),
    .mem_req_o(req32), .mem_we_o(we32), .mem_addr_o(maddr32), .mem_sel_o(sel32),
    .mem_data_o(mdata32), .mem_ack_i(a32), .mem_data_i(rdata[31:0]),
    .wd_o(wd32), .wreg_o(wreg32), .wdata_o(wdata32), .stall_req_o(stall32),
    .exc_misalign_o(mis32), .bus_err_o(err32)
  );

  mem_lsu #(.XLEN(64), .TIMEOUT(255)) d64 (
    .clk(clk), .rst(rst), .op_valid_i(v64), .op_load_i(ld), .op_store_i(st),
    .op_size_i(size), .op_unsigned_i(uns), .addr_i(addr), .reg2_i(reg2),
    .wd_i(wd_in), .wreg_i(wreg_in), .wdata_i(wdata_in),
    .mem_req_o(req64), .mem_we_o(we64), .mem_addr_o(maddr64), .mem_sel_o(sel64),
    .mem_data_o(mdata64), .mem_ack_i(a64), .mem_data_i(rdata),
    .wd_o(wd64), .wreg_o(wreg64), .wdata_o(wdata64), .stall_req_o(stall64),
    .exc_misalign_o(mis64), .bus_err_o(err64)
  );

  logic        o_req, o_we, o_wreg, o_stall, o_mis, o_err;
  logic [63:0] o_maddr, o_mdata, o_wdata;
  logic [7:0]  o_sel;
  logic [4:0]  o_wd;

  always_comb begin
    if (use64) begin
      o_req = req64; o_we = we64; o_wreg = wreg64; o_stall = stall64; o_mis = mis64; o_err = err64;
      o_maddr = maddr64; o_mdata = mdata64; o_wdata = wdata64; o_sel = sel64; o_wd = wd64;
    end else begin
      o_req = req32; o_we = we32; o_wreg = wreg32; o_stall = stall32; o_mis = mis32; o_err = err32;
      o_maddr = {32'h0, maddr32}; o_mdata = {32'h0, mdata32}; o_wdata = {32'h0, wdata32};
      o_sel = {4'h0, sel32}; o_wd = wd32;
    end
  end

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int errors = 0;
  int checks = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
    end
  endtask

  // Reference model: lanes/bytes from plain address arithmetic.
  function automatic vec_t model(input vec_t t);
    vec_t r;
    longint unsigned n, nb, al, off, val, v, m, w;
    r  = t;
    nb = t.is64 ? 8 : 4;
    w  = t.is64 ? 64'hFFFF_FFFF_FFFF_FFFF : 64'hFFFF_FFFF;
    n  = (!t.is64 && t.sz == 2'd3) ? 4 : (64'd1 << t.sz);
    al = t.addr - (t.addr % n);
    off = al % nb;
    r.e_addr = al & w;
    r.e_sel  = 8'(((64'd1 << n) - 1) << off);
    m   = (n == 8) ? 64'hFFFF_FFFF_FFFF_FFFF : ((64'd1 << (8 * n)) - 1);
    val = t.reg2 & m;
    r.e_mdata = 0;
    for (int k = 0; k < int'(nb / n); k++) r.e_mdata = r.e_mdata | (val << (8 * n * 64'(k)));
    r.e_mdata = r.e_mdata & w;
    v = (t.rdata >> (8 * off)) & m;
    if (!t.uns && n < 8 && v >= (64'd1 << (8 * n - 1))) v = v - (64'd1 << (8 * n));
    r.e_wdata = v & w;
    return r;
  endfunction

  // Entered and left at posedge+1 with the DUT idle.
  task automatic run_op(input vec_t t);
    int unsigned tmo, waits, stalls, exp_waits, n;
    bit memop, mis, err;
    logic [4:0] wd_lat;
    logic [63:0] w;
    tmo   = t.is64 ? 255 : 8;
    w     = t.is64 ? 64'hFFFF_FFFF_FFFF_FFFF : 64'hFFFF_FFFF;
    memop = t.ld ^ t.st;
    n     = (!t.is64 && t.sz == 2'd3) ? 4 : (32'd1 << t.sz);
    mis   = (t.addr % 64'(n)) != 0;
    err   = t.dly >= tmo;
    exp_waits = err ? tmo : t.dly + 1;
    use64 = t.is64; ld = t.ld; st = t.st; size = t.sz; uns = t.uns;
    addr = t.addr; reg2 = t.reg2; rdata = t.rdata;
    wd_in = 5'($urandom); wreg_in = 1'b1; wdata_in = {$urandom, $urandom};
    valid = 1'b1;
    #3;
    if (!memop) begin
      chk("pass_wd", 64'(o_wd), 64'(wd_in));
      chk("pass_wreg", 64'(o_wreg), 64'd1);
      chk("pass_wdata", o_wdata, wdata_in & w);
      chk("pass_stall", 64'(o_stall), 64'd0);
      chk("pass_req", 64'(o_req), 64'd0);
      @(posedge clk); #1;
      valid = 1'b0;
      return;
    end
    chk("accept_stall", 64'(o_stall), 64'd1);
    wd_lat = wd_in;
    @(posedge clk); #1;
    valid = 1'b0; wd_in = ~wd_lat; wreg_in = 1'b0;
    if (TRAP && mis) begin
      #3;
      chk("trap_exc", 64'(o_mis), 64'd1);
      chk("trap_req", 64'(o_req), 64'd0);
      chk("trap_wreg", 64'(o_wreg), 64'd0);
      chk("trap_stall", 64'(o_stall), 64'd0);
      @(posedge clk); #1;
      return;
    end
    stalls = 1; waits = 0;
    for (int unsigned k = 0; k < 300; k++) begin
      ackv = (k == t.dly);
      #3;
      waits++;
      if (o_stall) stalls++;
      if (k == 0) begin
        chk("wait_req", 64'(o_req), 64'd1);
        chk("wait_we", 64'(o_we), 64'(t.st));
        chk("wait_addr", o_maddr, t.e_addr);
        chk("wait_sel", 64'(o_sel), 64'(t.e_sel));
        if (t.st) chk("wait_sdata", o_mdata, t.e_mdata);
      end
      @(posedge clk); #1;
      ackv = 1'b0;
      if (k == t.dly || k == tmo - 1) break;
    end
    #3;
    chk("resp_stall", 64'(o_stall), 64'd0);
    chk("resp_req", 64'(o_req), 64'd0);
    chk("resp_err", 64'(o_err), 64'(err));
    chk("resp_exc", 64'(o_mis), 64'd0);
    chk("resp_wreg", 64'(o_wreg), 64'(t.ld && !err));
    chk("resp_wd", 64'(o_wd), 64'(wd_lat));
    if (t.ld && !err) chk("resp_wdata", o_wdata, t.e_wdata);
    chk("wait_cycles", 64'(waits), 64'(exp_waits));
    chk("stall_cycles", 64'(stalls), 64'(exp_waits + 1));
    @(posedge clk); #1;
    wreg_in = 1'b1; wd_in = 5'($urandom);
    #3;
    chk("idle_err", 64'(o_err), 64'd0);
    chk("idle_req", 64'(o_req), 64'd0);
    chk("idle_wreg", 64'(o_wreg), 64'd1);
    chk("idle_wd", 64'(o_wd), 64'(wd_in));
    @(posedge clk); #1;
    wreg_in = 1'b0;
  endtask

  vec_t tv[14];

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got no finish, want finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    tv[0]  = '{1'b0, 1'b1, 1'b0, 2'd0, 1'b0, 64'h103, 64'h0, 64'h80FF_0000, 0, 64'h103, 8'h08, 64'h0, 64'hFFFF_FF80};
    tv[1]  = '{1'b0, 1'b0, 1'b1, 2'd1, 1'b0, 64'h202, 64'h1234_ABCD, 64'h0, 3, 64'h202, 8'h0C, 64'hABCD_ABCD, 64'h0};
    tv[2]  = '{1'b1, 1'b1, 1'b0, 2'd2, 1'b1, 64'h14, 64'h0, 64'h8765_4321_0000_0000, 0, 64'h14, 8'hF0, 64'h0, 64'h8765_4321};
    tv[3]  = '{1'b0, 1'b1, 1'b0, 2'd2, 1'b0, 64'h101, 64'h0, 64'hDEAD_BEEF, 0, 64'h100, 8'h0F, 64'h0, 64'hDEAD_BEEF};
    tv[4]  = '{1'b0, 1'b1, 1'b0, 2'd1, 1'b0, 64'h2, 64'h0, 64'h8001_0000, 1, 64'h2, 8'h0C, 64'h0, 64'hFFFF_8001};
    tv[5]  = '{1'b0, 1'b1, 1'b0, 2'd0, 1'b1, 64'h1, 64'h0, 64'h0000_F000, 0, 64'h1, 8'h02, 64'h0, 64'hF0};
    tv[6]  = '{1'b0, 1'b1, 1'b0, 2'd2, 1'b0, 64'h40, 64'h0, 64'h5555_5555, 20, 64'h40, 8'h0F, 64'h0, 64'h0};
    tv[7]  = '{1'b0, 1'b1, 1'b0, 2'd2, 1'b0, 64'h44, 64'h0, 64'h1122_3344, 7, 64'h44, 8'h0F, 64'h0, 64'h1122_3344};
    tv[8]  = '{1'b0, 1'b0, 1'b1, 2'd0, 1'b0, 64'h7, 64'hAABB_CC5A, 64'h0, 0, 64'h7, 8'h08, 64'h5A5A_5A5A, 64'h0};
    tv[9]  = '{1'b0, 1'b1, 1'b0, 2'd3, 1'b0, 64'h8, 64'h0, 64'h9000_0001, 2, 64'h8, 8'h0F, 64'h0, 64'h9000_0001};
    tv[10] = '{1'b1, 1'b0, 1'b1, 2'd3, 1'b0, 64'h18, 64'h0123_4567_89AB_CDEF, 64'h0, 1, 64'h18, 8'hFF, 64'h0123_4567_89AB_CDEF, 64'h0};
    tv[11] = '{1'b1, 1'b1, 1'b0, 2'd1, 1'b0, 64'h6, 64'h0, 64'hFFFE_0000_0000_0000, 0, 64'h6, 8'hC0, 64'h0, 64'hFFFF_FFFF_FFFF_FFFE};
    tv[12] = '{1'b1, 1'b0, 1'b1, 2'd2, 1'b0, 64'h4, 64'hFFFF_FFFF_CAFE_F00D, 64'h0, 0, 64'h4, 8'hF0, 64'hCAFE_F00D_CAFE_F00D, 64'h0};
    tv[13] = '{1'b1, 1'b1, 1'b0, 2'd0, 1'b0, 64'h15, 64'h0, 64'h0000_7F00_0000_0000, 4, 64'h15, 8'h20, 64'h0, 64'h7F};

    rst = 1'b0; valid = 1'b1; use64 = 1'b0; ackv = 1'b0; ld = 1'b1; st = 1'b0; uns = 1'b0;
    size = 2'd2; addr = 64'h40; reg2 = '1; rdata = '1; wdata_in = '1; wd_in = 5'h1F; wreg_in = 1'b1;
    #2;
    chk("rst_req", 64'(o_req), 64'd0);
    chk("rst_stall", 64'(o_stall), 64'd0);
    chk("rst_wreg", 64'(o_wreg), 64'd0);
    chk("rst_wd", 64'(o_wd), 64'd0);
    chk("rst_wdata", o_wdata, 64'd0);
    chk("rst_bus", {o_maddr[31:0], o_mdata[31:0]} | 64'({o_sel, o_we, o_mis, o_err}), 64'd0);
    use64 = 1'b1;
    #1;
    chk("rst64_all", o_maddr | o_mdata | o_wdata | 64'({o_sel, o_wd, o_req, o_we, o_wreg, o_stall, o_mis, o_err}), 64'd0);
    valid = 1'b0; wreg_in = 1'b0;
    @(negedge clk); rst = 1'b1;
    @(posedge clk); #1;

    foreach (tv[i]) run_op(tv[i]);

    // ack while idle must be ignored
    use64 = 1'b0; ackv = 1'b1;
    for (int i = 0; i < 2; i++) begin
      #3;
      chk("idle_ack_req", 64'(o_req), 64'd0);
      chk("idle_ack_stall", 64'(o_stall), 64'd0);
      @(posedge clk); #1;
    end
    ackv = 1'b0;
    run_op(tv[1]);

    // reset dropped in the middle of WAIT
    use64 = 1'b0; ld = 1'b1; st = 1'b0; size = 2'd2; addr = 64'h40; wreg_in = 1'b1; valid = 1'b1;
    @(posedge clk); #1;
    valid = 1'b0;
    @(posedge clk); #1;
    #2;
    chk("rstw_req_before", 64'(o_req), 64'd1);
    rst = 1'b0; ackv = 1'b1;
    #1;
    chk("rstw_req_async", 64'(o_req), 64'd0);
    chk("rstw_stall_async", 64'(o_stall), 64'd0);
    @(posedge clk); #1;
    @(negedge clk); rst = 1'b1; ackv = 1'b0; wreg_in = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #3;
      chk("rstw_req_after", 64'(o_req), 64'd0);
      chk("rstw_wreg_after", 64'(o_wreg), 64'd0);
      chk("rstw_stall_after", 64'(o_stall), 64'd0);
    end
    @(posedge clk); #1;

    for (int i = 0; i < 40; i++) begin
      vec_t r;
      int unsigned kind;
      r.is64 = 1'($urandom_range(0, 1));
      kind   = $urandom_range(0, 5);
      r.ld   = (kind < 2) || (kind == 4);
      r.st   = (kind == 2) || (kind == 3) || (kind == 4);
      r.sz   = 2'($urandom_range(0, 3));
      r.uns  = 1'($urandom_range(0, 1));
      r.addr = r.is64 ? {$urandom, $urandom} : {32'h0, $urandom};
      if ($urandom_range(0, 1) == 1) r.addr = r.addr & ~64'h7;
      r.reg2  = {$urandom, $urandom};
      r.rdata = {$urandom, $urandom};
      r.dly   = r.is64 ? $urandom_range(0, 4) : $urandom_range(0, 9);
      r = model(r);
      run_op(r);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
